// File: rtl/trigger_pulse_gen.sv
// Multi-channel trigger pulse generator: each channel emits N timed pulses on Up/Down,
// plus a free-running divided clock and an all-idle ready flag.
module trigger_pulse_gen #(
  parameter int NCH    = 4,
  parameter int CNT_W  = 8,
  parameter int HI_CYC = 4,
  parameter int LO_CYC = 4,
  parameter int CLKDIV = 5,
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Cmd_Valid,
  output logic             Cmd_Ready,
  input  logic [CW-1:0]    Cmd_Chan,
  input  logic             Cmd_Dir,
  input  logic [CNT_W-1:0] Cmd_Count,
  input  logic             Cmd_Abort,
  output logic             Clk_out,
  output logic [NCH-1:0]   Up_Out,
  output logic [NCH-1:0]   Down_Out,
  output logic [NCH-1:0]   Busy,
  output logic             ready_out
);

  localparam int PMAX = (HI_CYC > LO_CYC) ? HI_CYC : LO_CYC;
  localparam int PW   = $clog2(PMAX + 1);
  localparam int DW   = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  state_t           state_q [NCH];
  state_t           state_d [NCH];
  logic [PW-1:0]    phase_q [NCH];
  logic [PW-1:0]    phase_d [NCH];
  logic [CNT_W-1:0] rem_q   [NCH];
  logic [CNT_W-1:0] rem_d   [NCH];
  logic [NCH-1:0]   dir_q;
  logic [NCH-1:0]   dir_d;
  logic             chan_hit;
  logic             sel_busy;
  logic             accept;
  logic [DW-1:0]    div_q;

  always_comb begin
    Up_Out   = '0;
    Down_Out = '0;
    Busy     = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      Up_Out[c]   = (state_q[c] == HIGH) & dir_q[c];
      Down_Out[c] = (state_q[c] == HIGH) & ~dir_q[c];
      Busy[c]     = (state_q[c] != IDLE);
    end
  end

  assign ready_out = ~|Busy;

  // Channel lookup by loop so an out-of-range index simply finds no channel.
  always_comb begin
    chan_hit = 1'b0;
    sel_busy = 1'b0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (Cmd_Chan == CW'(c)) begin
        chan_hit = 1'b1;
        sel_busy = Busy[c];
      end
    end
    Cmd_Ready = Reset & ~Cmd_Abort & chan_hit & ~sel_busy;
  end

  assign accept = Cmd_Valid & Cmd_Ready;

  always_comb begin
    for (int unsigned c = 0; c < NCH; c++) begin
      state_d[c] = state_q[c];
      phase_d[c] = phase_q[c];
      rem_d[c]   = rem_q[c];
      dir_d[c]   = dir_q[c];
      if (Cmd_Abort) begin
        state_d[c] = IDLE;
        phase_d[c] = '0;
      end else begin
        case (state_q[c])
          IDLE: begin
            if (accept && (Cmd_Chan == CW'(c))) begin
              dir_d[c]   = Cmd_Dir;
              rem_d[c]   = Cmd_Count;
              phase_d[c] = '0;
              if (Cmd_Count != '0) state_d[c] = HIGH;
            end
          end
          HIGH: begin
            if (phase_q[c] == PW'(HI_CYC - 1)) begin
              state_d[c] = LOW;
              phase_d[c] = '0;
              if (rem_q[c] != '0) rem_d[c] = rem_q[c] - CNT_W'(1);
            end else begin
              phase_d[c] = phase_q[c] + PW'(1);
            end
          end
          LOW: begin
            if (phase_q[c] == PW'(LO_CYC - 1)) begin
              phase_d[c] = '0;
              state_d[c] = (rem_q[c] != '0) ? HIGH : IDLE;
            end else begin
              phase_d[c] = phase_q[c] + PW'(1);
            end
          end
          default: state_d[c] = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        state_q[c] <= IDLE;
        phase_q[c] <= '0;
        rem_q[c]   <= '0;
      end
      dir_q <= '0;
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        state_q[c] <= state_d[c];
        phase_q[c] <= phase_d[c];
        rem_q[c]   <= rem_d[c];
      end
      dir_q <= dir_d;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      div_q   <= '0;
      Clk_out <= 1'b0;
    end else if (div_q == DW'(CLKDIV - 1)) begin
      div_q   <= '0;
      Clk_out <= ~Clk_out;
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

endmodule

// File: tb/tb_trigger_pulse_gen.sv
// Directed bench for trigger_pulse_gen at default parameters (4 ch, 4/4 pulse, div 5).
module tb_trigger_pulse_gen;

  logic       Clk;
  logic       Reset;
  logic       Cmd_Valid;
  logic       Cmd_Ready;
  logic [1:0] Cmd_Chan;
  logic       Cmd_Dir;
  logic [7:0] Cmd_Count;
  logic       Cmd_Abort;
  logic       Clk_out;
  logic [3:0] Up_Out;
  logic [3:0] Down_Out;
  logic [3:0] Busy;
  logic       ready_out;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_up;
  logic [3:0] exp_down;
  logic [3:0] exp_busy;
  logic       exp_bit;

  trigger_pulse_gen #(
    .NCH(4), .CNT_W(8), .HI_CYC(4), .LO_CYC(4), .CLKDIV(5)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready),
    .Cmd_Chan(Cmd_Chan), .Cmd_Dir(Cmd_Dir), .Cmd_Count(Cmd_Count),
    .Cmd_Abort(Cmd_Abort), .Clk_out(Clk_out), .Up_Out(Up_Out),
    .Down_Out(Down_Out), .Busy(Busy), .ready_out(ready_out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    @(negedge Clk);
    checks++;
    if (Up_Out !== 4'b0 || Down_Out !== 4'b0 || Busy !== 4'b0) begin
      failures++;
      $display("FAIL reset_outs: up=%b down=%b busy=%b expected all 0", Up_Out, Down_Out, Busy);
    end
    checks++;
    if (Clk_out !== 1'b0 || Cmd_Ready !== 1'b0 || ready_out !== 1'b1) begin
      failures++;
      $display("FAIL reset_flags: clk_out=%b cmd_ready=%b ready_out=%b expected 0 0 1",
               Clk_out, Cmd_Ready, ready_out);
    end
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    checks++;
    if (Cmd_Ready !== 1'b1 || ready_out !== 1'b1 || Busy !== 4'b0) begin
      failures++;
      $display("FAIL post_reset_idle: cmd_ready=%b ready_out=%b busy=%b expected 1 1 0000",
               Cmd_Ready, ready_out, Busy);
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge Clk);
      exp_bit = ((k / 5) % 2) == 1;
      checks++;
      if (Clk_out !== exp_bit) begin
        failures++;
        $display("FAIL clk_out_period k=%0d: got %b expected %b", k, Clk_out, exp_bit);
      end
    end
  endtask

  task automatic test_pulse_train();
    @(negedge Clk);
    Cmd_Chan = 2'd2; Cmd_Dir = 1'b1; Cmd_Count = 8'd3; Cmd_Valid = 1'b1;
    #1;
    checks++;
    if (Cmd_Ready !== 1'b1) begin
      failures++;
      $display("FAIL train_ready: got %b expected 1", Cmd_Ready);
    end
    @(negedge Clk);
    Cmd_Valid = 1'b0;
    for (int i = 0; i < 26; i++) begin
      exp_up   = (i < 24 && (i % 8) < 4) ? 4'b0100 : 4'b0000;
      exp_busy = (i < 24) ? 4'b0100 : 4'b0000;
      checks++;
      if (Up_Out !== exp_up || Down_Out !== 4'b0 || Busy !== exp_busy ||
          ready_out !== (exp_busy == 4'b0)) begin
        failures++;
        $display("FAIL train i=%0d: up=%b down=%b busy=%b rdy=%b expected up=%b down=0000 busy=%b rdy=%b",
                 i, Up_Out, Down_Out, Busy, ready_out, exp_up, exp_busy, exp_busy == 4'b0);
      end
      if (i < 25) @(negedge Clk);
    end
  endtask

  task automatic test_busy_reject();
    @(negedge Clk);
    Cmd_Chan = 2'd2; Cmd_Dir = 1'b1; Cmd_Count = 8'd3; Cmd_Valid = 1'b1;
    @(negedge Clk);
    Cmd_Valid = 1'b0;
    for (int i = 0; i < 28; i++) begin
      exp_up   = (i < 24 && (i % 8) < 4) ? 4'b0100 : 4'b0000;
      exp_down = (i >= 4 && i < 8) ? 4'b0001 : 4'b0000;
      exp_busy = ((i < 24) ? 4'b0100 : 4'b0000) | ((i >= 4 && i < 12) ? 4'b0001 : 4'b0000);
      checks++;
      if (Up_Out !== exp_up || Down_Out !== exp_down || Busy !== exp_busy ||
          ready_out !== (exp_busy == 4'b0)) begin
        failures++;
        $display("FAIL concurrent i=%0d: up=%b down=%b busy=%b rdy=%b expected up=%b down=%b busy=%b rdy=%b",
                 i, Up_Out, Down_Out, Busy, ready_out, exp_up, exp_down, exp_busy, exp_busy == 4'b0);
      end
      if (i == 2) begin
        Cmd_Chan = 2'd2; Cmd_Dir = 1'b0; Cmd_Count = 8'd5; Cmd_Valid = 1'b1;
        #1;
        checks++;
        if (Cmd_Ready !== 1'b0) begin
          failures++;
          $display("FAIL busy_chan_ready: got %b expected 0", Cmd_Ready);
        end
      end else if (i == 3) begin
        Cmd_Chan = 2'd0; Cmd_Dir = 1'b0; Cmd_Count = 8'd1; Cmd_Valid = 1'b1;
        #1;
        checks++;
        if (Cmd_Ready !== 1'b1) begin
          failures++;
          $display("FAIL idle_chan_ready: got %b expected 1", Cmd_Ready);
        end
      end else begin
        Cmd_Valid = 1'b0;
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_zero_count();
    @(negedge Clk);
    Cmd_Chan = 2'd1; Cmd_Dir = 1'b1; Cmd_Count = 8'd0; Cmd_Valid = 1'b1;
    #1;
    checks++;
    if (Cmd_Ready !== 1'b1) begin
      failures++;
      $display("FAIL zero_ready: got %b expected 1", Cmd_Ready);
    end
    @(negedge Clk);
    Cmd_Valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (Busy !== 4'b0 || Up_Out !== 4'b0 || Down_Out !== 4'b0 || ready_out !== 1'b1) begin
        failures++;
        $display("FAIL zero_count i=%0d: busy=%b up=%b down=%b rdy=%b expected 0000 0000 0000 1",
                 i, Busy, Up_Out, Down_Out, ready_out);
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_abort();
    @(negedge Clk);
    Cmd_Chan = 2'd2; Cmd_Dir = 1'b1; Cmd_Count = 8'd3; Cmd_Valid = 1'b1;
    @(negedge Clk);
    Cmd_Valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp_up = ((i % 8) < 4) ? 4'b0100 : 4'b0000;
      checks++;
      if (Up_Out !== exp_up || Busy !== 4'b0100) begin
        failures++;
        $display("FAIL abort_pre i=%0d: up=%b busy=%b expected up=%b busy=0100", i, Up_Out, Busy, exp_up);
      end
      if (i < 9) @(negedge Clk);
    end
    Cmd_Abort = 1'b1; Cmd_Valid = 1'b1; Cmd_Chan = 2'd0; Cmd_Dir = 1'b0; Cmd_Count = 8'd2;
    #1;
    checks++;
    if (Cmd_Ready !== 1'b0 || Up_Out !== 4'b0100) begin
      failures++;
      $display("FAIL abort_same_cycle: cmd_ready=%b up=%b expected 0 0100", Cmd_Ready, Up_Out);
    end
    @(negedge Clk);
    Cmd_Abort = 1'b0; Cmd_Valid = 1'b0;
    checks++;
    if (Up_Out !== 4'b0 || Busy !== 4'b0 || ready_out !== 1'b1) begin
      failures++;
      $display("FAIL abort_effect: up=%b busy=%b rdy=%b expected 0000 0000 1", Up_Out, Busy, ready_out);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      checks++;
      if (Busy !== 4'b0 || Down_Out !== 4'b0) begin
        failures++;
        $display("FAIL abort_no_accept i=%0d: busy=%b down=%b expected 0000 0000", i, Busy, Down_Out);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge Clk);
    Cmd_Chan = 2'd2; Cmd_Dir = 1'b1; Cmd_Count = 8'd3; Cmd_Valid = 1'b1;
    @(negedge Clk);
    Cmd_Valid = 1'b0;
    checks++;
    if (Up_Out !== 4'b0100) begin
      failures++;
      $display("FAIL reset_mid_pre: up=%b expected 0100", Up_Out);
    end
    @(negedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    checks++;
    if (Up_Out !== 4'b0 || Down_Out !== 4'b0 || Busy !== 4'b0 || ready_out !== 1'b1 ||
        Clk_out !== 1'b0 || Cmd_Ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_async: up=%b down=%b busy=%b rdy=%b clk_out=%b cmd_ready=%b expected 0000 0000 0000 1 0 0",
               Up_Out, Down_Out, Busy, ready_out, Clk_out, Cmd_Ready);
    end
    @(negedge Clk);
    Reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      checks++;
      if (Busy !== 4'b0 || Up_Out !== 4'b0 || Down_Out !== 4'b0) begin
        failures++;
        $display("FAIL reset_mid_no_resume i=%0d: busy=%b up=%b down=%b expected all 0",
                 i, Busy, Up_Out, Down_Out);
      end
    end
  endtask

  initial begin
    Reset = 1'b0; Cmd_Valid = 1'b0; Cmd_Chan = 2'd0; Cmd_Dir = 1'b0;
    Cmd_Count = 8'd0; Cmd_Abort = 1'b0;
    test_reset();
    test_pulse_train();
    test_busy_reject();
    test_zero_count();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
